// File: rtl/des_mmio_slave.sv
// rtl/des_mmio_slave.sv - memory-mapped DES coprocessor on the CPU data bus
// Operands are frozen at the start store; the combinational DES path gets LATENCY cycles to settle.
module des_mmio_slave #(
   parameter logic [15:0] BASE    = 16'h0100,
   parameter int          LATENCY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        memwrite,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        hit,
   output logic        irq
);

   localparam int IP_T [64] = '{
      58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
      62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
      57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
      61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int FP_T [64] = '{
      40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
      38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
      36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
      34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
   localparam int E_T [48] = '{
      32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13, 12,13,14,15,16,17,
      16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32, 1};
   localparam int P_T [32] = '{
      16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
       2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};
   localparam int PC1_T [56] = '{
      57,49,41,33,25,17, 9,  1,58,50,42,34,26,18, 10, 2,59,51,43,35,27,
      19,11, 3,60,52,44,36, 63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
      14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};
   localparam int PC2_T [48] = '{
      14,17,11,24, 1, 5,  3,28,15, 6,21,10, 23,19,12, 4,26, 8, 16, 7,27,20,13, 2,
      41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
   localparam int SBOX [512] = '{
      14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
      15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
      10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
       7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
       2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
      12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
       4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
      13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

   // Bit numbering follows the DES tables: position 1 is the MSB of each vector.
   function automatic logic [63:0] des_crypt(input logic [63:0] din, input logic [63:0] key,
                                             input logic dec);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [47:0] sk [16];
      logic [63:0] ip, pre, dout;
      logic [31:0] l, r, s, f, tmp;
      logic [47:0] e, k;
      logic [5:0]  six;
      for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
      c = cd[55:28];
      d = cd[27:0];
      for (int rd = 0; rd < 16; rd++) begin
         if (rd == 0 || rd == 1 || rd == 8 || rd == 15) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end else begin
            c = {c[25:0], c[27:26]};
            d = {d[25:0], d[27:26]};
         end
         cd = {c, d};
         for (int i = 0; i < 48; i++) sk[rd][47-i] = cd[56-PC2_T[i]];
      end
      for (int i = 0; i < 64; i++) ip[63-i] = din[64-IP_T[i]];
      l = ip[63:32];
      r = ip[31:0];
      for (int rd = 0; rd < 16; rd++) begin
         k = dec ? sk[15-rd] : sk[rd];
         for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
         e = e ^ k;
         for (int b = 0; b < 8; b++) begin
            six = e[47-6*b -: 6];
            s[31-4*b -: 4] = 4'(SBOX[b*64 + int'({six[5], six[0], six[4:1]})]);
         end
         for (int i = 0; i < 32; i++) f[31-i] = s[32-P_T[i]];
         tmp = r;
         r   = l ^ f;
         l   = tmp;
      end
      pre = {r, l};
      for (int i = 0; i < 64; i++) dout[63-i] = pre[64-FP_T[i]];
      return dout;
   endfunction

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_nx;
   logic [31:0] msg_hi, msg_lo, key_hi, key_lo, res_hi, res_lo;
   logic [63:0] op_msg, op_key, enc_out, dec_out;
   logic        mode_reg, op_mode, err;
   logic [3:0]  cnt;
   logic [2:0]  sel;
   logic        wr, ld, busy, done, start, capture;
   logic        unused_addr;

   assign unused_addr = ^{addr[31:16], addr[1:0]};
   assign sel     = addr[4:2];
   assign hit     = (addr[15:5] == BASE[15:5]);
   assign wr      = hit & memwrite;
   assign ld      = hit & ~memwrite;
   assign busy    = (state == RUN);
   assign done    = (state == DONE);
   assign irq     = done;
   assign start   = wr && (sel == 3'd4) && writedata[0] && !busy;
   assign capture = busy && (cnt == 4'd0);
   assign enc_out = des_crypt(op_msg, op_key, 1'b0);
   assign dec_out = des_crypt(op_msg, op_key, 1'b1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = RUN;
         RUN:  if (cnt == 4'd0) state_nx = DONE;
         DONE: begin
            if (start)                     state_nx = RUN;
            else if (ld && sel == 3'd7)    state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         msg_hi <= '0; msg_lo <= '0; key_hi <= '0; key_lo <= '0;
         res_hi <= '0; res_lo <= '0; op_msg <= '0; op_key <= '0;
         mode_reg <= 1'b0; op_mode <= 1'b0; err <= 1'b0; cnt <= '0;
      end else begin
         if (wr && !busy) begin
            case (sel)
               3'd0: msg_hi <= writedata;
               3'd1: msg_lo <= writedata;
               3'd2: key_hi <= writedata;
               3'd3: key_lo <= writedata;
               3'd4: mode_reg <= writedata[1];
               default: ;
            endcase
         end
         // One bus access per cycle, so the set and clear of err never collide.
         if (wr && busy && sel <= 3'd4)              err <= 1'b1;
         else if (wr && sel == 3'd5 && writedata[3]) err <= 1'b0;
         if (start) begin
            op_msg  <= {msg_hi, msg_lo};
            op_key  <= {key_hi, key_lo};
            op_mode <= writedata[1];
            cnt     <= 4'(LATENCY - 1);
         end else if (busy && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (capture) {res_hi, res_lo} <= op_mode ? dec_out : enc_out;
      end
   end

   always_comb begin
      readdata = '0;
      if (hit) begin
         case (sel)
            3'd0: readdata = msg_hi;
            3'd1: readdata = msg_lo;
            3'd2: readdata = key_hi;
            3'd3: readdata = key_lo;
            3'd4: readdata = {30'b0, mode_reg, 1'b0};
            3'd5: readdata = {28'b0, err, mode_reg, done, busy};
            3'd6: readdata = res_hi;
            default: readdata = res_lo;
         endcase
      end
   end

endmodule

// File: tb/tb_des_mmio_slave.sv
// tb/tb_des_mmio_slave.sv - directed bench for des_mmio_slave
module tb_des_mmio_slave;
   localparam logic [15:0] BASE     = 16'h0100;
   localparam logic [15:0] A_MSG_HI = BASE + 16'h00;
   localparam logic [15:0] A_MSG_LO = BASE + 16'h04;
   localparam logic [15:0] A_KEY_HI = BASE + 16'h08;
   localparam logic [15:0] A_KEY_LO = BASE + 16'h0C;
   localparam logic [15:0] A_CTRL   = BASE + 16'h10;
   localparam logic [15:0] A_STATUS = BASE + 16'h14;
   localparam logic [15:0] A_RES_HI = BASE + 16'h18;
   localparam logic [15:0] A_RES_LO = BASE + 16'h1C;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, writedata;
   logic        memwrite;
   logic [31:0] readdata4, readdata1;
   logic        hit4, hit1, irq4, irq1;
   logic [31:0] rd4, rd1;
   logic        h4, i4;
   int          checks = 0;
   int          errors = 0;

   des_mmio_slave #(.BASE(BASE), .LATENCY(4)) dut (
      .clk(clk), .reset(reset), .addr(addr), .memwrite(memwrite), .writedata(writedata),
      .readdata(readdata4), .hit(hit4), .irq(irq4));

   des_mmio_slave #(.BASE(BASE), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .addr(addr), .memwrite(memwrite), .writedata(writedata),
      .readdata(readdata1), .hit(hit1), .irq(irq1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sw(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = {16'h0, a}; memwrite = 1'b1; writedata = d;
      @(posedge clk); #1;
      addr = '0; memwrite = 1'b0; writedata = '0;
   endtask

   task automatic lw(input logic [15:0] a);
      @(negedge clk);
      addr = {16'h0, a}; memwrite = 1'b0;
      #1;
      rd4 = readdata4; rd1 = readdata1; h4 = hit4; i4 = irq4;
      @(posedge clk); #1;
      addr = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_op(input logic [63:0] m, input logic [63:0] k);
      sw(A_MSG_HI, m[63:32]); sw(A_MSG_LO, m[31:0]);
      sw(A_KEY_HI, k[63:32]); sw(A_KEY_LO, k[31:0]);
   endtask

   initial begin
      reset = 1'b0; addr = '0; memwrite = 1'b0; writedata = '0;
      idle(2);
      lw(A_STATUS); chk("rst_status", rd4, 32'h0); chk("rst_irq", {31'b0, i4}, 32'h0);
      @(negedge clk); reset = 1'b1;

      // reset in the middle of an operation
      load_op(64'h01234567_89ABCDEF, 64'h13345779_9BBCDFF1);
      sw(A_CTRL, 32'h1);
      lw(A_STATUS); chk("run_busy", rd4, 32'h1);
      @(negedge clk); reset = 1'b0;
      lw(A_MSG_HI); chk("rst_msg_hi", rd4, 32'h0);
      lw(A_KEY_LO); chk("rst_key_lo", rd4, 32'h0);
      lw(A_STATUS); chk("rst_mid_status", rd4, 32'h0); chk("rst_mid_irq", {31'b0, i4}, 32'h0);
      lw(A_RES_LO); chk("rst_res_lo", rd4, 32'h0);
      @(negedge clk); reset = 1'b1;
      idle(6);
      lw(A_STATUS); chk("post_rst_status", rd4, 32'h0);
      lw(A_RES_HI); chk("post_rst_res_hi", rd4, 32'h0);

      // encrypt
      load_op(64'h01234567_89ABCDEF, 64'h13345779_9BBCDFF1);
      sw(A_CTRL, 32'h1);
      for (int i = 0; i < 4; i++) begin
         lw(A_STATUS); chk("enc_busy", rd4, 32'h1);
      end
      lw(A_STATUS); chk("enc_done", rd4, 32'h2); chk("enc_irq", {31'b0, i4}, 32'h1);
      lw(A_RES_HI); chk("enc_res_hi", rd4, 32'h85E81354);
      lw(A_RES_LO); chk("enc_res_lo", rd4, 32'h0F0AB405);

      // decrypt
      sw(A_MSG_HI, 32'h85E81354); sw(A_MSG_LO, 32'h0F0AB405);
      sw(A_CTRL, 32'h3);
      idle(4);
      lw(A_STATUS); chk("dec_status", rd4, 32'h6);
      lw(A_RES_HI); chk("dec_res_hi", rd4, 32'h01234567);
      lw(A_RES_LO); chk("dec_res_lo", rd4, 32'h89ABCDEF);

      // stores while busy are dropped and flag err
      sw(A_MSG_HI, 32'h01234567); sw(A_MSG_LO, 32'h89ABCDEF);
      sw(A_CTRL, 32'h1);
      sw(A_MSG_LO, 32'hFFFFFFFF);
      sw(A_CTRL, 32'h1);
      idle(2);
      lw(A_STATUS); chk("busy_err_status", rd4, 32'hA);
      lw(A_MSG_LO); chk("busy_msg_lo_kept", rd4, 32'h89ABCDEF);
      sw(A_STATUS, 32'h8);
      lw(A_STATUS); chk("err_clear", rd4, 32'h2);

      // done clear by RES_LO load
      lw(A_RES_HI); chk("busy_res_hi", rd4, 32'h85E81354);
      lw(A_STATUS); chk("done_after_res_hi", rd4, 32'h2);
      lw(A_RES_LO); chk("busy_res_lo", rd4, 32'h0F0AB405);
      lw(A_STATUS); chk("done_cleared", rd4, 32'h0);
      lw(A_RES_LO); chk("res_lo_reread", rd4, 32'h0F0AB405);

      // restart from DONE
      sw(A_CTRL, 32'h1);
      idle(4);
      lw(A_STATUS); chk("pre_restart_done", rd4, 32'h2);
      sw(A_CTRL, 32'h1);
      lw(A_STATUS); chk("restart_busy", rd4, 32'h1); chk("restart_irq", {31'b0, i4}, 32'h0);
      idle(3);
      lw(A_STATUS); chk("restart_done", rd4, 32'h2);

      // address decode
      lw(BASE + 16'h20); chk("miss_hi_hit", {31'b0, h4}, 32'h0); chk("miss_hi_data", rd4, 32'h0);
      lw(BASE - 16'h4);  chk("miss_lo_hit", {31'b0, h4}, 32'h0); chk("miss_lo_data", rd4, 32'h0);
      sw(A_RES_HI, 32'hDEADBEEF);
      lw(A_RES_HI); chk("res_hi_ro", rd4, 32'h85E81354); chk("res_hi_hit", {31'b0, h4}, 32'h1);

      // LATENCY=1 instance
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      load_op(64'h01234567_89ABCDEF, 64'h13345779_9BBCDFF1);
      sw(A_CTRL, 32'h1);
      lw(A_STATUS); chk("l1_enc_busy", rd1, 32'h1);
      lw(A_STATUS); chk("l1_enc_done", rd1, 32'h2);
      lw(A_RES_HI); chk("l1_enc_res_hi", rd1, 32'h85E81354);
      lw(A_RES_LO); chk("l1_enc_res_lo", rd1, 32'h0F0AB405);
      sw(A_MSG_HI, 32'h85E81354); sw(A_MSG_LO, 32'h0F0AB405);
      sw(A_CTRL, 32'h3);
      lw(A_STATUS); chk("l1_dec_busy", rd1, 32'h5);
      lw(A_STATUS); chk("l1_dec_done", rd1, 32'h6);
      lw(A_RES_HI); chk("l1_dec_res_hi", rd1, 32'h01234567);
      lw(A_RES_LO); chk("l1_dec_res_lo", rd1, 32'h89ABCDEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
